group_feeder: RTL

GROUP_FEEDER -- requirements
Module: group_feeder

---
 rtl/group_feeder_pkg.sv | 19 +
 rtl/group_feeder_byte_fifo.sv | 61 ++++++
 rtl/group_feeder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/group_feeder_pkg.sv
// Shared defaults and FSM encoding for the group feeder slice.
package group_feeder_pkg;

  localparam int GROUP_LEN_DEF  = 128;
  localparam int FIFO_DEPTH_DEF = 256;
  localparam int GAP_CYCLES_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    GAP   = 2'b10
  } state_t;

  // Forces the downstream byte to zero on any cycle that carries no group data.
  function automatic logic [7:0] gate_byte(input logic en, input logic [7:0] b);
    return en ? b : 8'h00;
  endfunction

endpackage

// File: rtl/group_feeder_byte_fifo.sv
// Single-clock byte FIFO with show-ahead read data and an occupancy count.
module byte_fifo #(
  parameter int DEPTH = 256
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  assign wr_ok_s = wr_en && (count_r != FULL_CNT);
  assign rd_ok_s = rd_en && (count_r != ZERO_CNT);
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Storage array; power-of-two depth lets pointers wrap by overflow.
  always_ff @(posedge CLK) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= ZERO_CNT;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/group_feeder.sv
// Buffers upstream bytes and releases them as fixed-length groups separated by idle gaps.
module group_feeder
  import group_feeder_pkg::*;
#(
  parameter int GROUP_LEN  = GROUP_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    input_data,
  output logic                          data_start,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [15:0]                   groups_sent
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(GROUP_LEN + 1);
  localparam logic [FW-1:0] GROUP_THR  = FW'(GROUP_LEN);
  localparam logic [FW-1:0] FULL_LVL   = FW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BURST_LAST = BW'(GROUP_LEN - 1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  localparam logic [BW-1:0] BURST_ZERO = BW'(0);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYCLES);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [BW-1:0] burst_cnt_r;
  logic [7:0]    gap_cnt_r;
  logic          pop_s;
  logic          first_s;
  logic          last_s;
  logic          wr_en_s;
  logic [7:0]    fifo_rd_s;
  logic [FW-1:0] fill_s;
  logic [7:0]    input_data_r;
  logic          data_start_r;
  logic          data_valid_r;
  logic [15:0]   groups_sent_r;

  assign in_ready    = (fill_s != FULL_LVL);
  assign wr_en_s     = in_valid && in_ready;
  assign fill_level  = fill_s;
  assign input_data  = input_data_r;
  assign data_start  = data_start_r;
  assign data_valid  = data_valid_r;
  assign groups_sent = groups_sent_r;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (wr_en_s),
    .wr_data (in_data),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_s),
    .count   (fill_s)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and pop control; the first pop happens in the IDLE cycle that sees the threshold.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    first_s     = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (fill_s >= GROUP_THR) begin
          pop_s       = 1'b1;
          first_s     = 1'b1;
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        pop_s = 1'b1;
        if (burst_cnt_r == BURST_LAST) begin
          last_s      = 1'b1;
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = BURST;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Burst counter holds pops completed so far; gap counter spans GAP_CYCLES+1 state cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      burst_cnt_r <= BURST_ZERO;
      gap_cnt_r   <= 8'h00;
    end else begin
      if (first_s) begin
        burst_cnt_r <= BURST_ONE;
      end else if (state_r == BURST) begin
        burst_cnt_r <= burst_cnt_r + BURST_ONE;
      end else begin
        burst_cnt_r <= BURST_ZERO;
      end
      if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r + 8'h01;
      end else begin
        gap_cnt_r <= 8'h00;
      end
    end
  end

  // Registered downstream outputs and completed-group count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      input_data_r  <= 8'h00;
      data_start_r  <= 1'b0;
      data_valid_r  <= 1'b0;
      groups_sent_r <= 16'h0000;
    end else begin
      input_data_r <= gate_byte(pop_s, fifo_rd_s);
      data_start_r <= first_s;
      data_valid_r <= pop_s;
      if (last_s) begin
        groups_sent_r <= groups_sent_r + 16'h0001;
      end
    end
  end

endmodule
